adc_multi_reader: RTL and testbench
===================================

// Module: adc_multi_reader
//
// PURPOSE
//   Multi-channel serial ADC deserializer. CHANNELS serial lines share one bit clock and frame;
//   each line carries one DATLEN-bit sample per frame.
//   Shifts all lanes in parallel and emits one packed word per frame on a valid/ready interface.
//   Sits between the ADC pins and the downstream sample FIFO/FFT front end.
//   Flags words that are dropped under backpressure.
//
// PARAMETERS
//   DATLEN     12  bits per sample per channel (2..32)
//   CHANNELS   4   number of serial lanes (1..16)
//   MSB_FIRST  1   1: first bit received becomes sample MSB; 0: first bit becomes LSB
//
// PORTS
//   clk        in   1                sample clock; one bit per lane per rising edge
//   rst        in   1                asynchronous reset, active-high
//   adc_in     in   CHANNELS         serial bit per lane; lane c on adc_in[c]
//   adc_sync   in   1                frame start (present only with ADC_SYNC_EN)
//   out_data   out  CHANNELS*DATLEN  packed samples; lane c at [c*DATLEN +: DATLEN]
//   out_valid  out  1                out_data holds an unconsumed frame
//   out_ready  in   1                consumer accepts when out_valid && out_ready
//   ovf        out  1                sticky: a completed frame was dropped
//   ovf_clr    in   1                clears ovf
//   bit_cnt    out  clog2(DATLEN)    index of the next bit to be sampled (debug)
//
// BEHAVIOUR
//   Reset (async, while rst=1): all shift registers=0, bit_cnt=0, out_data=0, out_valid=0, ovf=0.
//   Counting: bit_cnt increments every edge; after DATLEN-1 it wraps to 0. No idle gaps.
//   Shifting: every edge each lane shifts adc_in[c] into its shift register.
//     MSB_FIRST=1: sreg <= {sreg[DATLEN-2:0], in}.
//     MSB_FIRST=0: sreg <= {in, sreg[DATLEN-1:1]}.
//   Completion: on the edge where bit_cnt==DATLEN-1, the shifted value including the current bit
//     forms the frame. Latency: out_valid rises in the cycle after the last bit's edge.
//   Accepting the completed frame (the edge where bit_cnt==DATLEN-1):
//     - if out_valid=0, or the frame currently in out_data is being accepted on this same edge:
//       out_data <= new frame, out_valid <= 1;
//     - otherwise the new frame is dropped, out_data is unchanged, and ovf <= 1.
//   Handshake: a transfer occurs on an edge with out_valid && out_ready. After a transfer,
//     out_valid <= 0 unless a new frame loads on the same edge.
//     out_data is stable while out_valid=1 and the frame is not accepted.
//   ovf: sticky. Cleared by ovf_clr=1 on an edge. If a drop and ovf_clr occur on the same edge,
//     the drop wins and ovf stays 1.
//   Reset mid-frame: the partial frame is discarded; counting restarts at bit 0 after rst falls.
//
// CONFIGURATION
//   ADC_SYNC_EN defined:
//     - adc_sync port exists.
//     - Edge with adc_sync=1: the bit sampled on that edge is bit 0; bit_cnt <= 1 (0 if DATLEN==1
//       is not allowed, so 1); shift registers are loaded with that bit only.
//     - A partial frame in progress is discarded silently, with no ovf and no output.
//     - adc_sync=1 on the edge where bit_cnt==DATLEN-1: sync wins; no frame completes.
//   ADC_SYNC_EN undefined:
//     - No adc_sync port.
//     - Free-running framing from reset, identical to the counting rule above.
//
// TESTING  (DATLEN=12, CHANNELS=2, MSB_FIRST=1 unless stated)
//   1. Basic frame: rst pulse, then lane0 serial 0xA5C and lane1 serial 0x3F1, out_ready=1.
//      Expect out_valid=1 for exactly 1 cycle, 12 cycles after the first bit, with out_data=24'h3F1A5C.
//   2. Back-to-back frames: 4 consecutive frames with out_ready=1.
//      Expect 4 valid pulses spaced 12 cycles apart, correct data each time, ovf=0.
//   3. Backpressure: out_ready=0 across two frame completions.
//      Expect frame 1 held in out_data, frame 2 dropped, ovf=1.
//      Then raise ovf_clr for 1 cycle -> ovf=0.
//   4. Same-edge accept: out_ready rises exactly on the completion edge of frame 2.
//      Expect frame 1 transferred, frame 2 loaded, out_valid stays 1, ovf=0.
//   5. Async reset mid-frame: assert rst after 5 bits, with no clock edge.
//      Expect immediate out_valid=0, bit_cnt=0. The next full 12 bits yield a correct frame.
//   6. ADC_SYNC_EN: pulse adc_sync after 7 bits, then send 12 bits of 0x800 on both lanes.
//      Expect one frame 24'h800800, no ovf, and no output from the partial frame.
//      With MSB_FIRST=0, the same serial stream yields 24'h001001.

Source files
------------

// File: rtl/adc_multi_reader.sv
// Multi-lane serial ADC deserializer: shifts CHANNELS lanes in parallel and emits one packed
// word per DATLEN-bit frame on a valid/ready port. Optional frame sync input via ADC_SYNC_EN.
module adc_multi_reader #(
    parameter int DATLEN    = 12,
    parameter int CHANNELS  = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          adc_in,
`ifdef ADC_SYNC_EN
    input  logic                         adc_sync,
`endif
    output logic [CHANNELS*DATLEN-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         ovf,
    input  logic                         ovf_clr,
    output logic [$clog2(DATLEN)-1:0]    bit_cnt
);

    localparam int CW = $clog2(DATLEN);
    localparam logic [CW-1:0] LAST = CW'(DATLEN - 1);

    logic [CHANNELS-1:0][DATLEN-1:0] sreg;
    logic [CHANNELS-1:0][DATLEN-1:0] sreg_nxt;
    logic [DATLEN-1:0]               base;
    logic                            sync_hit;
    logic                            frame_done;

`ifdef ADC_SYNC_EN
    assign sync_hit = adc_sync;
`else
    assign sync_hit = 1'b0;
`endif

    // A sync edge restarts the frame, so the current bit is shifted into an empty register.
    assign frame_done = (bit_cnt == LAST) && !sync_hit;

    always_comb begin
        sreg_nxt = '0;
        base     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            base = sync_hit ? '0 : sreg[c];
            if (MSB_FIRST != 0)
                sreg_nxt[c] = {base[DATLEN-2:0], adc_in[c]};
            else
                sreg_nxt[c] = {adc_in[c], base[DATLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            sreg <= sreg_nxt;

            if (sync_hit)
                bit_cnt <= CW'(1);
            else if (bit_cnt == LAST)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;

            // A held word being accepted on the completion edge frees the slot for the new frame.
            if (frame_done && (!out_valid || out_ready)) begin
                out_data  <= sreg_nxt;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (frame_done && out_valid && !out_ready)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_multi_reader.sv
// Directed bench for adc_multi_reader (DATLEN=12, CHANNELS=2): one MSB-first and one
// LSB-first instance share the same serial stimulus.
module tb_adc_multi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  adc_in = 2'b00;
    logic        adc_sync = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [23:0] out_data, out_data_l;
    logic        out_valid, out_valid_l;
    logic        ovf, ovf_l;
    logic [3:0]  bit_cnt, bit_cnt_l;

    int checks = 0;
    int failures = 0;
    int xfer_cnt = 0;

    adc_multi_reader #(.DATLEN(12), .CHANNELS(2), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .adc_in(adc_in),
`ifdef ADC_SYNC_EN
        .adc_sync(adc_sync),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .ovf_clr(ovf_clr), .bit_cnt(bit_cnt)
    );

    adc_multi_reader #(.DATLEN(12), .CHANNELS(2), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .adc_in(adc_in),
`ifdef ADC_SYNC_EN
        .adc_sync(adc_sync),
`endif
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .ovf(ovf_l), .ovf_clr(ovf_clr), .bit_cnt(bit_cnt_l)
    );

    always #5 clk = ~clk;

    // Transfers seen at mid-cycle; each held valid+ready cycle is one transfer.
    always @(negedge clk) begin
        if (out_valid && out_ready)
            xfer_cnt <= xfer_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick(input logic [1:0] bits, input logic rdy, input logic clr);
        adc_in    = bits;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    // Sends serial bits [11-from .. 11-to+1] of each lane (MSB of the word first on the wire).
    task automatic send_frame(input logic [11:0] l0, input logic [11:0] l1, input int from,
                              input int to, input logic [11:0] rdy_mask,
                              input logic [11:0] clr_mask);
        for (int i = from; i < to; i++)
            tick({l1[11-i], l0[11-i]}, rdy_mask[i], clr_mask[i]);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
        checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", out_data); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        send_frame(12'hA5C, 12'h3F1, 0, 5, 12'hFFF, 12'h000);
        checks++; if (bit_cnt !== 4'd5) begin failures++; $display("FAIL basic_bit_cnt got=%0d exp=5", bit_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        send_frame(12'hA5C, 12'h3F1, 5, 12, 12'hFFF, 12'h000);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 24'h3F1A5C) begin failures++; $display("FAIL basic_data got=%h exp=3f1a5c", out_data); end
        checks++; if (out_data_l !== 24'h8FC3A5) begin failures++; $display("FAIL basic_lsb_data got=%h exp=8fc3a5", out_data_l); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] f0 [4] = '{12'h123, 12'hFFF, 12'h800, 12'h5A5};
        logic [11:0] f1 [4] = '{12'hABC, 12'h000, 12'h001, 12'hA5A};
        logic [23:0] em [4] = '{24'hABC123, 24'h000FFF, 24'h001800, 24'hA5A5A5};
        logic [23:0] el [4] = '{24'h3D5C48, 24'h000FFF, 24'h800001, 24'h5A5A5A};
        int x0;
        x0 = xfer_cnt;
        for (int k = 0; k < 4; k++) begin
            send_frame(f0[k], f1[k], 0, 1, 12'hFFF, 12'h000);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_len frame=%0d got=%b exp=0", k, out_valid); end
            send_frame(f0[k], f1[k], 1, 12, 12'hFFF, 12'h000);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid frame=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_data !== em[k]) begin failures++; $display("FAIL b2b_data frame=%0d got=%h exp=%h", k, out_data, em[k]); end
            checks++; if (out_data_l !== el[k]) begin failures++; $display("FAIL b2b_lsb_data frame=%0d got=%h exp=%h", k, out_data_l, el[k]); end
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", ovf); end
        checks++; if (xfer_cnt - x0 !== 4) begin failures++; $display("FAIL b2b_xfers got=%0d exp=4", xfer_cnt - x0); end
    endtask

    task automatic test_backpressure;
        send_frame(12'h111, 12'h222, 0, 12, 12'h001, 12'h000);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL bp_first_ovf got=%b exp=0", ovf); end
        send_frame(12'h333, 12'h444, 0, 12, 12'h000, 12'h000);
        checks++; if (out_data !== 24'h222111) begin failures++; $display("FAIL bp_held_data got=%h exp=222111", out_data); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_drop_ovf got=%b exp=1", ovf); end
        send_frame(12'h0F0, 12'h00F, 0, 1, 12'hFFF, 12'h001);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL bp_clr_ovf got=%b exp=0", ovf); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
        send_frame(12'h0F0, 12'h00F, 1, 12, 12'hFFF, 12'h000);
        checks++; if (out_data !== 24'h00F0F0) begin failures++; $display("FAIL bp_next_data got=%h exp=00f0f0", out_data); end
        send_frame(12'h777, 12'h666, 0, 12, 12'h001, 12'h000);
        send_frame(12'h999, 12'h888, 0, 12, 12'h000, 12'h800);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_drop_beats_clr got=%b exp=1", ovf); end
        checks++; if (out_data !== 24'h666777) begin failures++; $display("FAIL bp_held_data2 got=%h exp=666777", out_data); end
    endtask

    task automatic test_same_edge;
        int x0;
        send_frame(12'hABC, 12'hDEF, 0, 12, 12'h001, 12'h001);
        checks++; if (out_data !== 24'hDEFABC) begin failures++; $display("FAIL se_first_data got=%h exp=defabc", out_data); end
        x0 = xfer_cnt;
        send_frame(12'h135, 12'h246, 0, 12, 12'h800, 12'h000);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL se_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 24'h246135) begin failures++; $display("FAIL se_data got=%h exp=246135", out_data); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL se_ovf got=%b exp=0", ovf); end
        checks++; if (xfer_cnt - x0 !== 1) begin failures++; $display("FAIL se_xfers got=%0d exp=1", xfer_cnt - x0); end
    endtask

    task automatic test_async_reset;
        send_frame(12'hFFF, 12'hFFF, 0, 5, 12'h000, 12'h000);
        checks++; if (bit_cnt !== 4'd5) begin failures++; $display("FAIL ar_pre_bit_cnt got=%0d exp=5", bit_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        checks++; if (bit_cnt !== 4'd0) begin failures++; $display("FAIL ar_bit_cnt got=%0d exp=0", bit_cnt); end
        checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL ar_data got=%h exp=000000", out_data); end
        #1;
        rst = 1'b0;
        send_frame(12'h6C3, 12'h39A, 0, 12, 12'hFFF, 12'h000);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_post_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 24'h39A6C3) begin failures++; $display("FAIL ar_post_data got=%h exp=39a6c3", out_data); end
    endtask

`ifdef ADC_SYNC_EN
    task automatic test_sync;
        int x0;
        send_frame(12'hFFF, 12'hFFF, 0, 7, 12'hFFF, 12'h000);
        x0 = xfer_cnt;
        adc_sync = 1'b1;
        tick(2'b11, 1'b1, 1'b0);
        adc_sync = 1'b0;
        checks++; if (bit_cnt !== 4'd1) begin failures++; $display("FAIL sync_bit_cnt got=%0d exp=1", bit_cnt); end
        send_frame(12'h800, 12'h800, 1, 11, 12'hFFF, 12'h000);
        checks++; if (xfer_cnt - x0 !== 0) begin failures++; $display("FAIL sync_partial_out got=%0d exp=0", xfer_cnt - x0); end
        send_frame(12'h800, 12'h800, 11, 12, 12'hFFF, 12'h000);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sync_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 24'h800800) begin failures++; $display("FAIL sync_data got=%h exp=800800", out_data); end
        checks++; if (out_data_l !== 24'h001001) begin failures++; $display("FAIL sync_lsb_data got=%h exp=001001", out_data_l); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sync_ovf got=%b exp=0", ovf); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_backpressure;
        test_same_edge;
        test_async_reset;
`ifdef ADC_SYNC_EN
        test_sync;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
